// File: rtl/zircon_vga_pkg.sv
// zircon_vga_pkg: shared timing constants for the Zircon VGA timing block.
//   - default 800x600@60 timing (40 MHz pixel clock) and derived totals
//   - counter widths for the horizontal and vertical axis counters
//   - raster FSM state encoding
package zircon_vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_t;

endpackage

// File: rtl/zircon_vga_axis_counter.sv
// zircon_vga_axis_counter: wrap counter for one raster axis.
//   clk  - pixel clock
//   clr  - synchronous load of INIT (highest priority)
//   en   - count enable
//   cnt  - current count, wraps TOTAL-1 -> 0
//   tc   - terminal count: high when enabled and at TOTAL-1 (wraps this edge)
module zircon_vga_axis_counter #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned TOTAL = 1056,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] INIT_L = WIDTH'(INIT);

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= INIT_L;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/zircon_avalon_vga_timing.sv
// zircon_avalon_vga_timing: VGA raster timing generator (default 800x600@60).
//   csi_clk         - pixel clock
//   rsi_reset       - synchronous, active-high reset
//   vga_enable      - run enable (VGA start bit), synchronous to csi_clk
//   coe_vga_hs/vs   - sync outputs to the connector (active level HS_POL/VS_POL)
//   vga_data_en     - high during active pixels (FIFO read request, RGB gate)
//   vga_frame_start - FIFO clear, high for the whole vertical sync interval
//   vga_pixel_x/y   - active column/row, 0 outside the active area
// All outputs are registered one cycle after the counter values.
module zircon_avalon_vga_timing
  import zircon_vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic               csi_clk,
  input  logic               rsi_reset,
  input  logic               vga_enable,
  output logic               coe_vga_hs,
  output logic               coe_vga_vs,
  output logic               vga_data_en,
  output logic               vga_frame_start,
  output logic [H_CNT_W-1:0] vga_pixel_x,
  output logic [V_CNT_W-1:0] vga_pixel_y
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_W-1:0] H_ACT_L  = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_ACT_L  = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_t         state;
  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               h_tc;
  logic               cnt_clr;
  logic               cnt_run;
  logic               h_act;
  logic               v_act;
  logic               hs_on;
  logic               vs_on;

  // Counters are parked at h=0, v=V_ACTIVE whenever not running, so every
  // start begins with a full vertical blanking interval.
  assign cnt_clr = rsi_reset || !vga_enable || (state == ST_IDLE);
  assign cnt_run = (state == ST_RUN);

  zircon_vga_axis_counter #(
    .WIDTH (H_CNT_W),
    .TOTAL (H_TOT),
    .INIT  (0)
  ) u_h_cnt (
    .clk (csi_clk),
    .clr (cnt_clr),
    .en  (cnt_run),
    .cnt (h_cnt),
    .tc  (h_tc)
  );

  // Frame end is not needed downstream; the vertical wrap is internal.
  zircon_vga_axis_counter #(
    .WIDTH (V_CNT_W),
    .TOTAL (V_TOT),
    .INIT  (V_ACTIVE)
  ) u_v_cnt (
    .clk (csi_clk),
    .clr (cnt_clr),
    .en  (h_tc),
    .cnt (v_cnt),
    .tc  ()
  );

  assign h_act = (h_cnt < H_ACT_L);
  assign v_act = (v_cnt < V_ACT_L);
  assign hs_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on = (v_cnt >= VS_START) && (v_cnt < VS_END);

  always_ff @(posedge csi_clk) begin
    if (rsi_reset || !vga_enable) begin
      state           <= ST_IDLE;
      coe_vga_hs      <= ~HS_POL;
      coe_vga_vs      <= ~VS_POL;
      vga_data_en     <= 1'b0;
      vga_frame_start <= 1'b0;
      vga_pixel_x     <= '0;
      vga_pixel_y     <= '0;
    end else begin
      state <= ST_RUN;
      if (state == ST_RUN) begin
        coe_vga_hs      <= hs_on ? HS_POL : ~HS_POL;
        coe_vga_vs      <= vs_on ? VS_POL : ~VS_POL;
        vga_data_en     <= h_act && v_act;
        vga_frame_start <= vs_on;
        vga_pixel_x     <= (h_act && v_act) ? h_cnt : '0;
        vga_pixel_y     <= (h_act && v_act) ? v_cnt : '0;
      end else begin
        coe_vga_hs      <= ~HS_POL;
        coe_vga_vs      <= ~VS_POL;
        vga_data_en     <= 1'b0;
        vga_frame_start <= 1'b0;
        vga_pixel_x     <= '0;
        vga_pixel_y     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_zircon_avalon_vga_timing.sv
// Bench for zircon_avalon_vga_timing: one default-timing instance (start-up
// and line timing) and one small-raster instance with inverted sync polarity
// (16+4+8+6 = 34 pixels/line, 10+1+3+2 = 16 lines/frame, 544 cycles/frame).
module tb_zircon_avalon_vga_timing;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, en_d, rst_s, en_s;
  logic        hs_d, vs_d, de_d, fs_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic        hs_s, vs_s, de_s, fs_s;
  logic [10:0] x_s;
  logic [9:0]  y_s;

  int total = 0;
  int bad   = 0;

  zircon_avalon_vga_timing dut_d (
    .csi_clk         (clk),
    .rsi_reset       (rst_d),
    .vga_enable      (en_d),
    .coe_vga_hs      (hs_d),
    .coe_vga_vs      (vs_d),
    .vga_data_en     (de_d),
    .vga_frame_start (fs_d),
    .vga_pixel_x     (x_d),
    .vga_pixel_y     (y_d)
  );

  zircon_avalon_vga_timing #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (6),
    .V_ACTIVE (10), .V_FP (1), .V_SYNC (3), .V_BP (2),
    .HS_POL   (1'b0), .VS_POL (1'b0)
  ) dut_s (
    .csi_clk         (clk),
    .rsi_reset       (rst_s),
    .vga_enable      (en_s),
    .coe_vga_hs      (hs_s),
    .coe_vga_vs      (vs_s),
    .vga_data_en     (de_s),
    .vga_frame_start (fs_s),
    .vga_pixel_x     (x_s),
    .vga_pixel_y     (y_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1; en_d = 1'b0; rst_s = 1'b1; en_s = 1'b0;
    repeat (3) tick();
    total++;
    if ({hs_d, vs_d, de_d, fs_d, x_d, y_d} !== {4'b0000, 11'd0, 10'd0}) begin
      bad++;
      $display("FAIL reset_dflt: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, want 0 0 0 0 0 0",
               hs_d, vs_d, de_d, fs_d, x_d, y_d);
    end
    total++;
    if ({hs_s, vs_s, de_s, fs_s, x_s, y_s} !== {4'b1100, 11'd0, 10'd0}) begin
      bad++;
      $display("FAIL reset_small: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, want 1 1 0 0 0 0",
               hs_s, vs_s, de_s, fs_s, x_s, y_s);
    end
    rst_d = 1'b0; rst_s = 1'b0;
    repeat (2) tick();
    total++;
    if ({hs_d, vs_d, de_d, fs_d} !== 4'b0000) begin
      bad++;
      $display("FAIL idle_dflt: got hs=%b vs=%b de=%b fs=%b, want 0 0 0 0", hs_d, vs_d, de_d, fs_d);
    end
  endtask

  // Default timing: start-up blanking, vs/frame_start width, first line, hs.
  task automatic test_default_timing();
    int n, vsw, diff, run, t, w, l;
    logic [10:0] lx;
    logic [9:0]  ly;
    en_d = 1'b1;
    tick();  // RUN entry edge
    total++;
    if ({vs_d, de_d, fs_d} !== 3'b000) begin
      bad++;
      $display("FAIL run_entry_dflt: got vs=%b de=%b fs=%b, want 0 0 0", vs_d, de_d, fs_d);
    end
    n = 0;
    while (vs_d !== 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 1057) begin bad++; $display("FAIL first_vs_dflt: got %0d cycles, want 1057", n); end
    vsw = 0; diff = 0;
    while (vs_d === 1'b1 && vsw < 10000) begin
      if (fs_d !== vs_d) diff++;
      vsw++; tick(); n++;
    end
    total++;
    if (vsw != 4224) begin bad++; $display("FAIL vs_width_dflt: got %0d, want 4224", vsw); end
    total++;
    if (diff != 0 || fs_d !== 1'b0) begin
      bad++;
      $display("FAIL fs_eq_vs_dflt: got %0d diffs fs_after=%b, want 0 diffs fs_after=0", diff, fs_d);
    end
    while (de_d !== 1'b1 && n < 40000) begin tick(); n++; end
    total++;
    if (n != 29569) begin bad++; $display("FAIL first_de_dflt: got %0d cycles, want 29569", n); end
    total++;
    if (x_d !== 11'd0 || y_d !== 10'd0 || fs_d !== 1'b0) begin
      bad++;
      $display("FAIL first_pix_dflt: got x=%0d y=%0d fs=%b, want 0 0 0", x_d, y_d, fs_d);
    end
    run = 0; lx = '0; ly = '0;
    while (de_d === 1'b1 && run < 2000) begin lx = x_d; ly = y_d; run++; tick(); end
    total++;
    if (run != 800 || lx !== 11'd799 || ly !== 10'd0 || x_d !== 11'd0) begin
      bad++;
      $display("FAIL line_de_dflt: got len=%0d last=(%0d,%0d) next_x=%0d, want 800 (799,0) 0",
               run, lx, ly, x_d);
    end
    t = run;
    while (hs_d !== 1'b1 && t < 3000) begin tick(); t++; end
    total++;
    if (t != 840) begin bad++; $display("FAIL hs_start_dflt: got %0d, want 840", t); end
    w = 0;
    while (hs_d === 1'b1 && w < 3000) begin tick(); w++; end
    total++;
    if (w != 128) begin bad++; $display("FAIL hs_width_dflt: got %0d, want 128", w); end
    l = 0;
    while (hs_d !== 1'b1 && l < 3000) begin tick(); l++; end
    total++;
    if (w + l != 1056) begin bad++; $display("FAIL hs_period_dflt: got %0d, want 1056", w + l); end
    en_d = 1'b0;
  endtask

  // Small raster: one full frame of measurements, includes the (33,15)->(0,0) wrap.
  task automatic test_small_frame();
    int n, vsw, diff, dcyc, dlines, ovl;
    logic prev_de;
    logic [10:0] lx, px, fx;
    logic [9:0]  ly, py, fy;
    en_s = 1'b1;
    tick();
    n = 0;
    while (vs_s !== 1'b0 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 35) begin bad++; $display("FAIL first_vs_small: got %0d, want 35", n); end
    vsw = 0; diff = 0;
    while (vs_s === 1'b0 && vsw < 2000) begin
      if (fs_s !== 1'b1) diff++;
      vsw++; tick(); n++;
    end
    total++;
    if (vsw != 102 || diff != 0 || fs_s !== 1'b0) begin
      bad++;
      $display("FAIL vs_fs_small: got width=%0d diffs=%0d fs_after=%b, want 102 0 0", vsw, diff, fs_s);
    end
    while (de_s !== 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 205 || x_s !== 11'd0 || y_s !== 10'd0) begin
      bad++;
      $display("FAIL first_de_small: got t=%0d (%0d,%0d), want 205 (0,0)", n, x_s, y_s);
    end
    dcyc = 0; dlines = 0; ovl = 0; prev_de = 1'b0;
    lx = '0; ly = '0; px = '0; py = '0; fx = '1; fy = '1;
    while (vs_s !== 1'b0 && n < 3000) begin
      if (de_s === 1'b1) begin dcyc++; if (!prev_de) dlines++; end
      if (de_s === 1'b1 && fs_s === 1'b1) ovl++;
      if (prev_de && de_s !== 1'b1) begin lx = px; ly = py; fx = x_s; fy = y_s; end
      prev_de = de_s; px = x_s; py = y_s;
      tick(); n++;
    end
    total++;
    if (dcyc != 160 || dlines != 10 || ovl != 0) begin
      bad++;
      $display("FAIL frame_de_small: got cycles=%0d lines=%0d overlap=%0d, want 160 10 0", dcyc, dlines, ovl);
    end
    total++;
    if (lx !== 11'd15 || ly !== 10'd9 || fx !== 11'd0 || fy !== 10'd0) begin
      bad++;
      $display("FAIL last_pix_small: got (%0d,%0d) then (%0d,%0d), want (15,9) then (0,0)", lx, ly, fx, fy);
    end
    total++;
    if (n != 579) begin bad++; $display("FAIL frame_period_small: got vs at %0d, want 579", n); end
    while (de_s !== 1'b1 && n < 3000) begin tick(); n++; end
    total++;
    if (n != 749 || x_s !== 11'd0 || y_s !== 10'd0) begin
      bad++;
      $display("FAIL wrap_small: got t=%0d (%0d,%0d), want 749 (0,0)", n, x_s, y_s);
    end
  endtask

  task automatic test_disable_mid_frame();
    int n;
    n = 0;
    while (!(de_s === 1'b1 && x_s === 11'd8 && y_s === 10'd5) && n < 2000) begin tick(); n++; end
    en_s = 1'b0;
    tick();
    total++;
    if ({hs_s, vs_s, de_s, fs_s, x_s, y_s} !== {4'b1100, 11'd0, 10'd0}) begin
      bad++;
      $display("FAIL disable_small: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d, want 1 1 0 0 0 0",
               hs_s, vs_s, de_s, fs_s, x_s, y_s);
    end
    repeat (5) tick();
    en_s = 1'b1;
    tick();
    n = 0;
    while (vs_s !== 1'b0 && de_s !== 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 35 || fs_s !== 1'b1 || de_s !== 1'b0) begin
      bad++;
      $display("FAIL reenable_blank_small: got t=%0d fs=%b de=%b, want 35 1 0", n, fs_s, de_s);
    end
    while (de_s !== 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 205) begin bad++; $display("FAIL reenable_de_small: got %0d, want 205", n); end
  endtask

  task automatic test_reset_priority();
    int n;
    n = 0;
    while (fs_s !== 1'b1 && n < 2000) begin tick(); n++; end
    tick();
    rst_s = 1'b1;
    tick();
    total++;
    if (fs_s !== 1'b0 || vs_s !== 1'b1 || de_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_prio_small: got fs=%b vs=%b de=%b, want 0 1 0", fs_s, vs_s, de_s);
    end
    tick();
    rst_s = 1'b0;
    tick();
    n = 0;
    while (vs_s !== 1'b0 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 35) begin bad++; $display("FAIL restart_vs_small: got %0d, want 35", n); end
    while (de_s !== 1'b1 && n < 2000) begin tick(); n++; end
    total++;
    if (n != 205 || x_s !== 11'd0 || y_s !== 10'd0) begin
      bad++;
      $display("FAIL restart_de_small: got t=%0d (%0d,%0d), want 205 (0,0)", n, x_s, y_s);
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_small_frame();
    test_disable_mid_frame();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
